rmgmt_mem_arbiter: RTL and testbench
====================================

RMGMT_MEM_ARBITER -- requirements
Module: rmgmt_mem_arbiter

Interface
REQ-001 SHALL have parameter RMGMT_PRIORITY, default 1, meaning that RISC-MGMT wins simultaneous requests when 1 and the pipeline wins when 0.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, the number of consecutive priority-side grants a waiting loser tolerates.
REQ-003 SHALL have port CLK  in  1  system clock, all state on rising edge.
REQ-004 SHALL have port nRST  in  1  reset, synchronous and active-low.
REQ-005 SHALL have ports pipe_addr  in  32, pipe_wdata  in  32, pipe_byte_en  in  4, pipe_ren  in  1, pipe_wen  in  1: execute-stage data request.
REQ-006 SHALL have ports pipe_rdata  out  32 (load data) and pipe_busy  out  1 (pipeline request not yet complete).
REQ-007 SHALL have ports rm_req_mem  in  1, rm_addr  in  32, rm_store  in  32, rm_ren  in  1, rm_wen  in  1: RISC-MGMT extension request.
REQ-008 SHALL have ports rm_load  out  32 and rm_busy  out  1, which drive mem_load and mem_busy of the RISC-MGMT interface.
REQ-009 SHALL have ports bus_addr  out  32, bus_wdata  out  32, bus_byte_en  out  4, bus_ren  out  1, bus_wen  out  1, bus_rdata  in  32, bus_busy  in  1: generic data bus to memory.

Function
REQ-010 Request definitions: pipe_req = pipe_ren|pipe_wen; rm_req = rm_req_mem&(rm_ren|rm_wen). Each requestor SHALL hold its signals stable until its busy is low.
REQ-011 FSM states SHALL be IDLE, GNT_PIPE, GNT_RM.
REQ-012 IDLE: bus_ren=bus_wen=0; on any request, select a winner per REQ-016 and enter the matching GNT state on the next edge.
REQ-013 GNT_x: the bus SHALL be driven from the winner's inputs; for RISC-MGMT, bus_byte_en=4'hF and bus_wdata=rm_store.
REQ-014 Completion is a GNT_x cycle with bus_busy=0. In that cycle the winner's busy SHALL be 0 and its rdata SHALL equal bus_rdata combinationally. bus_rdata SHALL also be captured into the winner's hold register.
REQ-015 On completion, if the other requestor is pending, the FSM SHALL move directly to its GNT state (back-to-back, no IDLE cycle); otherwise it SHALL return to IDLE.
REQ-016 Arbitration when both requestors are pending: the priority side wins unless starve_cnt==STARVE_LIMIT, in which case the non-priority side wins. A single pending requestor always wins.
REQ-017 starve_cnt SHALL increment on each priority-side grant made while the other side is pending, saturating at STARVE_LIMIT. It SHALL clear on any non-priority-side grant. Width is $clog2(STARVE_LIMIT+1).
REQ-018 x_busy SHALL be 1 whenever x_req=1 and x is not completing this cycle. x_busy SHALL be 0 when x_req=0.
REQ-019 x_rdata SHALL equal the hold register whenever x is not completing.
REQ-020 Requestor withdrawal mid-grant (e.g. a flush): the FSM SHALL stay in GNT_x until bus_busy=0, SHALL keep bus_ren/bus_wen as latched at grant, and SHALL discard the returned data (the hold register is not updated).
REQ-021 To support REQ-020, bus_ren, bus_wen and bus_addr SHALL be registered at grant time. Only data and byte enables pass through live.
REQ-022 Worst-case latency from request to completion SHALL be 1 + (bus wait cycles) + (one full competing transaction).

Reset
REQ-023 With nRST low at a clock edge, the FSM SHALL be IDLE, starve_cnt 0, hold registers 0 and latched bus controls 0, regardless of bus_busy.
REQ-024 Outputs after reset SHALL be bus_ren=bus_wen=0, bus_addr=0, pipe_rdata=rm_load=0. pipe_busy and rm_busy SHALL follow REQ-018.
REQ-025 Reset during an active grant SHALL abandon the transaction. The bus SHALL be idle from the first post-reset cycle.

Structure
REQ-026 The state enum type rmgmt_arb_state_t SHALL live in the shared RISC-MGMT package. word_t SHALL come from rv32i_types_pkg.
REQ-027 The block SHALL be implemented flat, with no sub-module. The starvation counter is inline.

Verification
REQ-028 Pipeline load only, addr 0x100, bus_busy high for 2 cycles, rdata 0xDEADBEEF -> pipe_busy low in cycle 4, pipe_rdata=0xDEADBEEF, rm_busy=0 throughout.
REQ-029 Simultaneous pipeline read and RISC-MGMT write (0x200, 0x12345678), RMGMT_PRIORITY=1, zero-wait bus -> RM completes first with byte_en 4'hF, then pipeline completes back-to-back on the next cycle with no IDLE cycle.
REQ-030 Continuous rm_req with pipe_req held, STARVE_LIMIT=4 -> exactly 4 RM grants, then one pipeline grant, then starve_cnt=0.
REQ-031 Pipeline drops pipe_ren after 1 cycle of GNT_PIPE with bus_busy high for 3 more cycles -> bus_ren stays 1 until completion, pipe_rdata hold unchanged, then IDLE.
REQ-032 nRST low for 1 cycle while in GNT_RM with bus_busy=1 -> next cycle IDLE, bus_ren=bus_wen=0, rm_load=0, starve_cnt=0.

Source files
------------

// File: rtl/rmgmt_mem_arbiter_pkg.sv
// rtl/rmgmt_mem_arbiter_pkg.sv - shared RISC-MGMT types used by the memory arbiter
package rmgmt_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_GNT_PIPE = 2'd1,
    ARB_GNT_RM   = 2'd2
  } rmgmt_arb_state_t;

  // RISC-MGMT stores are always full-word.
  localparam logic [3:0] RM_BYTE_EN = 4'hF;

  // Contested arbitration: the priority side wins unless the other side is starved.
  function automatic logic rm_wins(input logic rm_is_prio, input logic starved);
    return rm_is_prio ^ starved;
  endfunction

endpackage

// File: rtl/rv32i_types_pkg.sv
// rtl/rv32i_types_pkg.sv - RV32I shared scalar types
package rv32i_types_pkg;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/rmgmt_mem_arbiter.sv
// rtl/rmgmt_mem_arbiter.sv - arbitrates pipeline and RISC-MGMT data requests onto one memory bus
module rmgmt_mem_arbiter
  import rv32i_types_pkg::*;
  import rmgmt_mem_arbiter_pkg::*;
#(
  parameter int RMGMT_PRIORITY = 1,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic       CLK,
  input  logic       nRST,
  input  word_t      pipe_addr,
  input  word_t      pipe_wdata,
  input  logic [3:0] pipe_byte_en,
  input  logic       pipe_ren,
  input  logic       pipe_wen,
  output word_t      pipe_rdata,
  output logic       pipe_busy,
  input  logic       rm_req_mem,
  input  word_t      rm_addr,
  input  word_t      rm_store,
  input  logic       rm_ren,
  input  logic       rm_wen,
  output word_t      rm_load,
  output logic       rm_busy,
  output word_t      bus_addr,
  output word_t      bus_wdata,
  output logic [3:0] bus_byte_en,
  output logic       bus_ren,
  output logic       bus_wen,
  input  word_t      bus_rdata,
  input  logic       bus_busy
);

  localparam int               CNT_W      = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(STARVE_LIMIT);
  localparam logic             RM_IS_PRIO = (RMGMT_PRIORITY != 0);

  rmgmt_arb_state_t state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             bus_ren_q, bus_ren_d;
  logic             bus_wen_q, bus_wen_d;
  word_t            bus_addr_q, bus_addr_d;
  word_t            pipe_hold_q, pipe_hold_d;
  word_t            rm_hold_q, rm_hold_d;

  logic pipe_req;
  logic rm_req;
  logic starved;
  logic contested;
  logic grant_pipe;
  logic grant_rm;
  logic prio_grant;
  logic nprio_grant;
  logic pipe_cmpl;
  logic rm_cmpl;

  assign pipe_req = pipe_ren | pipe_wen;
  assign rm_req   = rm_req_mem & (rm_ren | rm_wen);
  assign starved  = (starve_cnt_q == CNT_MAX);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= ARB_IDLE;
      starve_cnt_q <= '0;
      bus_ren_q    <= 1'b0;
      bus_wen_q    <= 1'b0;
      bus_addr_q   <= '0;
      pipe_hold_q  <= '0;
      rm_hold_q    <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      bus_ren_q    <= bus_ren_d;
      bus_wen_q    <= bus_wen_d;
      bus_addr_q   <= bus_addr_d;
      pipe_hold_q  <= pipe_hold_d;
      rm_hold_q    <= rm_hold_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    bus_ren_d    = bus_ren_q;
    bus_wen_d    = bus_wen_q;
    bus_addr_d   = bus_addr_q;
    pipe_hold_d  = pipe_hold_q;
    rm_hold_d    = rm_hold_q;
    contested    = 1'b0;
    grant_pipe   = 1'b0;
    grant_rm     = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (pipe_req && rm_req) begin
          contested  = 1'b1;
          grant_rm   = rm_wins(RM_IS_PRIO, starved);
          grant_pipe = !grant_rm;
        end else begin
          grant_pipe = pipe_req;
          grant_rm   = rm_req;
        end
      end
      // A withdrawn winner still waits out the bus, but its data is dropped.
      ARB_GNT_PIPE: begin
        if (!bus_busy) begin
          if (pipe_req) pipe_hold_d = bus_rdata;
          grant_rm = rm_req;
        end
      end
      ARB_GNT_RM: begin
        if (!bus_busy) begin
          if (rm_req) rm_hold_d = bus_rdata;
          grant_pipe = pipe_req;
        end
      end
      default: begin
        state_d   = ARB_IDLE;
        bus_ren_d = 1'b0;
        bus_wen_d = 1'b0;
      end
    endcase

    if (grant_pipe) begin
      state_d    = ARB_GNT_PIPE;
      bus_ren_d  = pipe_ren;
      bus_wen_d  = pipe_wen;
      bus_addr_d = pipe_addr;
    end else if (grant_rm) begin
      state_d    = ARB_GNT_RM;
      bus_ren_d  = rm_ren;
      bus_wen_d  = rm_wen;
      bus_addr_d = rm_addr;
    end else if (state_q != ARB_IDLE && !bus_busy) begin
      state_d   = ARB_IDLE;
      bus_ren_d = 1'b0;
      bus_wen_d = 1'b0;
    end

    prio_grant  = RM_IS_PRIO ? grant_rm : grant_pipe;
    nprio_grant = RM_IS_PRIO ? grant_pipe : grant_rm;
    if (nprio_grant) begin
      starve_cnt_d = '0;
    end else if (prio_grant && contested && !starved) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_comb begin
    bus_addr    = bus_addr_q;
    bus_ren     = 1'b0;
    bus_wen     = 1'b0;
    bus_wdata   = '0;
    bus_byte_en = '0;
    pipe_cmpl   = 1'b0;
    rm_cmpl     = 1'b0;

    case (state_q)
      ARB_GNT_PIPE: begin
        bus_ren     = bus_ren_q;
        bus_wen     = bus_wen_q;
        bus_wdata   = pipe_wdata;
        bus_byte_en = pipe_byte_en;
        pipe_cmpl   = !bus_busy && pipe_req;
      end
      ARB_GNT_RM: begin
        bus_ren     = bus_ren_q;
        bus_wen     = bus_wen_q;
        bus_wdata   = rm_store;
        bus_byte_en = RM_BYTE_EN;
        rm_cmpl     = !bus_busy && rm_req;
      end
      default: ;
    endcase

    pipe_busy  = pipe_req && !pipe_cmpl;
    rm_busy    = rm_req && !rm_cmpl;
    pipe_rdata = pipe_cmpl ? bus_rdata : pipe_hold_q;
    rm_load    = rm_cmpl ? bus_rdata : rm_hold_q;
  end

endmodule

// File: tb/tb_rmgmt_mem_arbiter.sv
// tb/tb_rmgmt_mem_arbiter.sv - directed and randomized bench for rmgmt_mem_arbiter
module tb_rmgmt_mem_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int PIPE = 1;
  localparam int RM   = 2;
  localparam int PRIO  = RM;
  localparam int NPRIO = PIPE;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] pipe_addr, pipe_wdata, pipe_rdata;
  logic [3:0]  pipe_byte_en;
  logic        pipe_ren, pipe_wen, pipe_busy;
  logic        rm_req_mem, rm_ren, rm_wen, rm_busy;
  logic [31:0] rm_addr, rm_store, rm_load;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_byte_en;
  logic        bus_ren, bus_wen, bus_busy;

  int n_cmp = 0;
  int n_err = 0;

  rmgmt_mem_arbiter #(.RMGMT_PRIORITY(1), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .CLK(CLK), .nRST(nRST),
    .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata), .pipe_byte_en(pipe_byte_en),
    .pipe_ren(pipe_ren), .pipe_wen(pipe_wen), .pipe_rdata(pipe_rdata), .pipe_busy(pipe_busy),
    .rm_req_mem(rm_req_mem), .rm_addr(rm_addr), .rm_store(rm_store), .rm_ren(rm_ren),
    .rm_wen(rm_wen), .rm_load(rm_load), .rm_busy(rm_busy),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_byte_en(bus_byte_en),
    .bus_ren(bus_ren), .bus_wen(bus_wen), .bus_rdata(bus_rdata), .bus_busy(bus_busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  // Reference model: owner of the bus, latched controls, hold values, grant history.
  typedef struct {int who; bit contested;} grant_t;
  grant_t      hist[$];
  grant_t      n_grant;
  bit          n_has_grant;
  bit          model_en = 1'b0;
  int          m_owner, n_owner;
  logic        m_ren, m_wen, n_ren, n_wen;
  logic [31:0] m_addr, n_addr, m_hp, n_hp, m_hr, n_hr;

  // Contested priority grants since the non-priority side was last served, capped.
  function automatic int m_starve();
    int cnt = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i].who == NPRIO) break;
      if (hist[i].contested) cnt++;
    end
    return (cnt > STARVE_LIMIT) ? STARVE_LIMIT : cnt;
  endfunction

  task automatic m_grant(input int who, input bit contested);
    n_owner     = who;
    n_ren       = (who == PIPE) ? pipe_ren : rm_ren;
    n_wen       = (who == PIPE) ? pipe_wen : rm_wen;
    n_addr      = (who == PIPE) ? pipe_addr : rm_addr;
    n_grant     = '{who: who, contested: contested};
    n_has_grant = 1'b1;
  endtask

  always @(negedge CLK) begin : model_cmp
    bit preq, rreq, done, pc, rc, other_req;
    if (model_en) begin
      preq = pipe_ren | pipe_wen;
      rreq = rm_req_mem & (rm_ren | rm_wen);
      done = (m_owner != 0) && !bus_busy;
      pc   = done && (m_owner == PIPE) && preq;
      rc   = done && (m_owner == RM) && rreq;
      check("m_bus_ren", {31'd0, bus_ren}, {31'd0, (m_owner != 0) ? m_ren : 1'b0});
      check("m_bus_wen", {31'd0, bus_wen}, {31'd0, (m_owner != 0) ? m_wen : 1'b0});
      if (m_owner != 0) begin
        check("m_bus_addr", bus_addr, m_addr);
        check("m_bus_wdata", bus_wdata, (m_owner == PIPE) ? pipe_wdata : rm_store);
        check("m_bus_be", {28'd0, bus_byte_en}, {28'd0, (m_owner == PIPE) ? pipe_byte_en : 4'hF});
      end
      check("m_pipe_busy", {31'd0, pipe_busy}, {31'd0, preq && !pc});
      check("m_rm_busy", {31'd0, rm_busy}, {31'd0, rreq && !rc});
      check("m_pipe_rdata", pipe_rdata, pc ? bus_rdata : m_hp);
      check("m_rm_load", rm_load, rc ? bus_rdata : m_hr);

      n_owner = m_owner; n_ren = m_ren; n_wen = m_wen; n_addr = m_addr;
      n_hp = m_hp; n_hr = m_hr; n_has_grant = 1'b0;
      if (m_owner == 0) begin
        if (preq && rreq) m_grant((m_starve() == STARVE_LIMIT) ? NPRIO : PRIO, 1'b1);
        else if (preq) m_grant(PIPE, 1'b0);
        else if (rreq) m_grant(RM, 1'b0);
      end else if (done) begin
        if (pc) n_hp = bus_rdata;
        if (rc) n_hr = bus_rdata;
        other_req = (m_owner == PIPE) ? rreq : preq;
        if (other_req) m_grant(3 - m_owner, 1'b0);
        else n_owner = 0;
      end
    end
  end

  always @(posedge CLK) begin
    if (!nRST) begin
      m_owner = 0; m_ren = 1'b0; m_wen = 1'b0; m_addr = '0; m_hp = '0; m_hr = '0;
      hist.delete();
      model_en = 1'b1;
    end else if (model_en) begin
      m_owner = n_owner; m_ren = n_ren; m_wen = n_wen; m_addr = n_addr;
      m_hp = n_hp; m_hr = n_hr;
      if (n_has_grant) hist.push_back(n_grant);
    end
  end

  initial begin
    bit p_done, r_done;
    int k;
    nRST = 1'b0;
    pipe_addr = '0; pipe_wdata = '0; pipe_byte_en = 4'hF; pipe_ren = 1'b0; pipe_wen = 1'b0;
    rm_req_mem = 1'b0; rm_addr = '0; rm_store = '0; rm_ren = 1'b0; rm_wen = 1'b0;
    bus_rdata = '0; bus_busy = 1'b1;
    step(); step();
    smp();
    check("rst_bus_ren", {31'd0, bus_ren}, 32'd0);
    check("rst_bus_wen", {31'd0, bus_wen}, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_pipe_rdata", pipe_rdata, 32'd0);
    check("rst_rm_load", rm_load, 32'd0);
    check("rst_pipe_busy", {31'd0, pipe_busy}, 32'd0);
    step(); nRST = 1'b1;

    // Pipeline load, two wait cycles.
    step(); pipe_addr = 32'h100; pipe_ren = 1'b1; bus_busy = 1'b1;
    smp(); check("ld_c1_busy", {31'd0, pipe_busy}, 32'd1); check("ld_c1_ren", {31'd0, bus_ren}, 32'd0);
    step();
    smp(); check("ld_c2_ren", {31'd0, bus_ren}, 32'd1); check("ld_c2_addr", bus_addr, 32'h100);
    check("ld_c2_busy", {31'd0, pipe_busy}, 32'd1); check("ld_c2_rm", {31'd0, rm_busy}, 32'd0);
    step();
    smp(); check("ld_c3_busy", {31'd0, pipe_busy}, 32'd1);
    step(); bus_busy = 1'b0; bus_rdata = 32'hDEADBEEF;
    smp(); check("ld_c4_busy", {31'd0, pipe_busy}, 32'd0); check("ld_c4_rdata", pipe_rdata, 32'hDEADBEEF);
    check("ld_c4_rm", {31'd0, rm_busy}, 32'd0);
    step(); pipe_ren = 1'b0; bus_rdata = 32'h0;
    smp(); check("ld_hold", pipe_rdata, 32'hDEADBEEF); check("ld_idle_ren", {31'd0, bus_ren}, 32'd0);

    // Simultaneous pipeline read and RISC-MGMT write, zero-wait bus.
    step(); pipe_addr = 32'h300; pipe_ren = 1'b1;
    rm_req_mem = 1'b1; rm_wen = 1'b1; rm_addr = 32'h200; rm_store = 32'h12345678;
    bus_busy = 1'b0; bus_rdata = 32'hAAAA0001;
    smp(); check("sim_idle_wen", {31'd0, bus_wen}, 32'd0);
    step();
    smp(); check("sim_rm_wen", {31'd0, bus_wen}, 32'd1); check("sim_rm_addr", bus_addr, 32'h200);
    check("sim_rm_wdata", bus_wdata, 32'h12345678); check("sim_rm_be", {28'd0, bus_byte_en}, 32'hF);
    check("sim_rm_busy", {31'd0, rm_busy}, 32'd0); check("sim_pipe_wait", {31'd0, pipe_busy}, 32'd1);
    step(); rm_req_mem = 1'b0; rm_wen = 1'b0; bus_rdata = 32'hAAAA0002;
    smp(); check("sim_b2b_ren", {31'd0, bus_ren}, 32'd1); check("sim_b2b_addr", bus_addr, 32'h300);
    check("sim_pipe_done", {31'd0, pipe_busy}, 32'd0); check("sim_pipe_rdata", pipe_rdata, 32'hAAAA0002);
    step(); pipe_ren = 1'b0;
    smp(); check("sim_idle_after", {31'd0, bus_ren}, 32'd0);

    // Starvation: contested RM grants with the pipeline flushing each time.
    bus_rdata = 32'h0BADF00D;
    for (int r = 0; r < 5; r++) begin
      step(); pipe_ren = 1'b1; pipe_addr = 32'h400; rm_req_mem = 1'b1; rm_ren = 1'b1; rm_addr = 32'h500;
      bus_busy = 1'b1;
      smp(); check("stv_idle", {31'd0, bus_ren}, 32'd0);
      step(); bus_busy = 1'b0;
      if (r < STARVE_LIMIT) begin
        pipe_ren = 1'b0;
        smp(); check("stv_rm_win", bus_addr, 32'h500); check("stv_rm_done", {31'd0, rm_busy}, 32'd0);
        step(); rm_req_mem = 1'b0; rm_ren = 1'b0;
        smp(); check("stv_back_idle", {31'd0, bus_ren}, 32'd0);
      end else begin
        smp(); check("stv_pipe_win", bus_addr, 32'h400); check("stv_rm_wait", {31'd0, rm_busy}, 32'd1);
        step(); pipe_ren = 1'b0;
        smp(); check("stv_b2b_rm", bus_addr, 32'h500); check("stv_b2b_done", {31'd0, rm_busy}, 32'd0);
        step(); rm_req_mem = 1'b0; rm_ren = 1'b0;
      end
    end
    step(); pipe_ren = 1'b1; pipe_addr = 32'h400; rm_req_mem = 1'b1; rm_ren = 1'b1; rm_addr = 32'h500;
    step();
    smp(); check("stv_cleared", bus_addr, 32'h500);
    step(); rm_req_mem = 1'b0; rm_ren = 1'b0;
    smp(); check("stv_final_pipe", bus_addr, 32'h400);
    step(); pipe_ren = 1'b0;

    // Pipeline withdraws after one grant cycle; bus stays busy three more cycles.
    step(); pipe_ren = 1'b1; pipe_addr = 32'h600; bus_busy = 1'b1; bus_rdata = 32'h11112222;
    step();
    smp(); check("wd_g1_ren", {31'd0, bus_ren}, 32'd1); check("wd_g1_busy", {31'd0, pipe_busy}, 32'd1);
    step(); pipe_ren = 1'b0;
    for (int i = 0; i < 3; i++) begin
      smp(); check("wd_hold_ren", {31'd0, bus_ren}, 32'd1); check("wd_hold_rdata", pipe_rdata, 32'h0BADF00D);
      step();
    end
    bus_busy = 1'b0;
    smp(); check("wd_last_ren", {31'd0, bus_ren}, 32'd1); check("wd_last_rdata", pipe_rdata, 32'h0BADF00D);
    step();
    smp(); check("wd_idle", {31'd0, bus_ren}, 32'd0); check("wd_kept", pipe_rdata, 32'h0BADF00D);

    // Reset in the middle of a busy RM grant.
    step(); rm_req_mem = 1'b1; rm_ren = 1'b1; rm_addr = 32'h700; bus_busy = 1'b1;
    step();
    smp(); check("rg_ren", {31'd0, bus_ren}, 32'd1); check("rg_load_pre", rm_load, 32'h0BADF00D);
    step(); nRST = 1'b0;
    step(); nRST = 1'b1;
    smp(); check("rg_ren_off", {31'd0, bus_ren}, 32'd0); check("rg_wen_off", {31'd0, bus_wen}, 32'd0);
    check("rg_load", rm_load, 32'd0); check("rg_addr", bus_addr, 32'd0);
    check("rg_busy", {31'd0, rm_busy}, 32'd1);
    step(); rm_req_mem = 1'b0; rm_ren = 1'b0; bus_busy = 1'b0;
    step();

    // Randomized traffic with flushes, wait states and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      smp();
      p_done = (pipe_ren | pipe_wen) && !pipe_busy;
      r_done = (rm_req_mem & (rm_ren | rm_wen)) && !rm_busy;
      step();
      if (p_done || ((pipe_ren | pipe_wen) && $urandom_range(0, 15) == 0)) begin
        pipe_ren = 1'b0; pipe_wen = 1'b0;
      end
      if (!(pipe_ren | pipe_wen) && $urandom_range(0, 2) == 0) begin
        k = $urandom_range(1, 3);
        pipe_ren = k[0]; pipe_wen = k[1];
        pipe_addr = $urandom; pipe_wdata = $urandom; pipe_byte_en = 4'($urandom);
      end
      if (r_done || (rm_req_mem && $urandom_range(0, 15) == 0)) begin
        rm_req_mem = 1'b0; rm_ren = 1'b0; rm_wen = 1'b0;
      end
      if (!rm_req_mem && $urandom_range(0, 2) == 0) begin
        k = $urandom_range(1, 3);
        rm_req_mem = 1'b1; rm_ren = k[0]; rm_wen = k[1];
        rm_addr = $urandom; rm_store = $urandom;
      end
      bus_busy  = ($urandom_range(0, 2) == 0);
      bus_rdata = $urandom;
      nRST      = ($urandom_range(0, 149) != 0);
    end
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
